// File: rtl/pocket_mux_n.sv
// rtl/pocket_mux_n.sv - priority hole video mux with per-frame pocket event queue
// Video path is a one-cycle registered priority mux; event path gathers per-frame hits into pending bits.
module pocket_mux_n #(
    parameter int NUM_HOLES = 6,
    parameter int RGB_W     = 8,
    parameter int ID_W      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic [NUM_HOLES-1:0]       hole_enable,
    input  logic [NUM_HOLES-1:0]       graphic_dr,
    input  logic [NUM_HOLES*RGB_W-1:0] graphic_rgb,
    input  logic [NUM_HOLES-1:0]       hit_dr,
    input  logic [NUM_HOLES*RGB_W-1:0] hit_rgb,
    output logic [RGB_W-1:0]           RGBOut,
    output logic                       Graphic_Hole_DR,
    output logic                       Hit_Hole_DR,
    output logic [ID_W-1:0]            Hole_ID,
    output logic                       event_valid,
    output logic [ID_W-1:0]            event_id,
    input  logic                       event_ready,
    output logic                       overrun
);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [NUM_HOLES-1:0] r_seen;
    logic [NUM_HOLES-1:0] r_pending;
    logic [ID_W-1:0]      r_event_id;
    logic                 r_overrun;

    logic [RGB_W-1:0]     w_rgb;
    logic                 w_gdr;
    logic                 w_hdr;
    logic [ID_W-1:0]      w_id;
    logic [NUM_HOLES-1:0] w_hits;
    logic [NUM_HOLES-1:0] w_clr;
    logic [NUM_HOLES-1:0] w_pend_next;
    logic                 w_accept;
    logic                 w_load;
    logic [ID_W-1:0]      w_load_id;

    // 1-based index of the lowest set bit, 0 when the vector is empty
    function automatic logic [ID_W-1:0] f_lowest(input logic [NUM_HOLES-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = NUM_HOLES - 1; i >= 0; i--) begin
            if (v[i]) r = ID_W'(i + 1);
        end
        return r;
    endfunction

    always_comb begin
        w_rgb = '0;
        w_gdr = 1'b0;
        w_hdr = 1'b0;
        w_id  = '0;
        for (int i = NUM_HOLES - 1; i >= 0; i--) begin
            if (graphic_dr[i] && hole_enable[i]) begin
                w_gdr = 1'b1;
                w_hdr = hit_dr[i];
                w_id  = ID_W'(i + 1);
                w_rgb = hit_dr[i] ? hit_rgb[i*RGB_W +: RGB_W] : graphic_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RGBOut          <= '0;
            Graphic_Hole_DR <= 1'b0;
            Hit_Hole_DR     <= 1'b0;
            Hole_ID         <= '0;
        end else begin
            RGBOut          <= w_rgb;
            Graphic_Hole_DR <= w_gdr;
            Hit_Hole_DR     <= w_hdr;
            Hole_ID         <= w_id;
        end
    end

    assign w_hits   = hole_enable & graphic_dr & hit_dr;
    assign w_accept = (r_state == S_OFFER) && event_ready;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            w_clr[i] = w_accept && (r_event_id == ID_W'(i + 1));
        end
    end

    // Hits on the frame_start cycle open the new frame's seen set
    assign w_pend_next = (r_pending & ~w_clr) | (frame_start ? r_seen : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen    <= '0;
            r_pending <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_seen    <= frame_start ? w_hits : (r_seen | w_hits);
            r_pending <= w_pend_next;
            if (frame_start && (r_pending != '0) && (r_seen != '0)) r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_event_id <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) r_event_id <= w_load_id;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_id    = f_lowest(w_pend_next);
        case (r_state)
            S_IDLE: begin
                if (r_pending != '0) begin
                    w_state_next = S_OFFER;
                    w_load       = 1'b1;
                    w_load_id    = f_lowest(r_pending);
                end
            end
            S_OFFER: begin
                if (event_ready) begin
                    if (w_pend_next != '0) w_load = 1'b1;
                    else                   w_state_next = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        event_valid = (r_state == S_OFFER);
        event_id    = r_event_id;
        overrun     = r_overrun;
    end

endmodule
